dec_vec_seq: RTL and testbench

- Vector instruction sequencer between decode and the shared scalar execution resources (ALU lane and LSU port).
- Accepts one decoded vector instruction (vv/xv/vi/vx arithmetic, v_load, v_store) and issues it element by element.
- Stalls decode while busy and signals completion to the commit logic.
- Unit-stride memory only; element size fixed at 32 bits.

---
 rtl/dec_vec_seq.sv | 185 ++++++++++++++++++
 tb/tb_dec_vec_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_vec_seq.sv
// rtl/dec_vec_seq.sv - vector instruction sequencer issuing element ops to the ALU lane and LSU port
// Optional performance counters are enabled with the RV_VEC_SEQ_PERF_EN macro.
module dec_vec_seq #(
   parameter int VL_MAX    = 8,
   parameter int VL_W      = 4,
   parameter int MAX_OUTST = 4
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            flush,
   input  logic            dec_v_valid,
   output logic            dec_v_ready,
   input  logic [1:0]      dec_v_kind,
   input  logic [VL_W-1:0] dec_v_vl,
   input  logic [4:0]      dec_v_vd,
   input  logic [4:0]      dec_v_vs1,
   input  logic [4:0]      dec_v_vs2,
   input  logic [31:0]     dec_v_base,
   output logic            alu_req_valid,
   input  logic            alu_req_ready,
   output logic [VL_W-1:0] alu_req_idx,
   output logic            alu_req_scalar,
   output logic            lsu_req_valid,
   input  logic            lsu_req_ready,
   output logic            lsu_req_store,
   output logic [31:0]     lsu_req_addr,
   output logic [VL_W-1:0] lsu_req_idx,
   input  logic            lsu_resp_valid,
   output logic [4:0]      vreg_vd,
   output logic [4:0]      vreg_vs1,
   output logic [4:0]      vreg_vs2,
   output logic            busy,
   output logic            done
`ifdef RV_VEC_SEQ_PERF_EN
   ,
   output logic [31:0]     perf_elem_cnt,
   output logic [31:0]     perf_stall_cnt
`endif
);

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam logic [OW-1:0]   OUTST_LIM = OW'(MAX_OUTST);
   localparam logic [VL_W-1:0] VL_LIM    = VL_W'(VL_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q;
   logic [1:0]      kind_q;
   logic [VL_W-1:0] vl_q;
   logic [VL_W-1:0] idx_q;
   logic [4:0]      vd_q;
   logic [4:0]      vs1_q;
   logic [4:0]      vs2_q;
   logic [31:0]     base_q;
   logic [OW-1:0]   outst_q;
   logic [OW-1:0]   outst_d;
   logic            flushed_q;

   logic is_mem;
   logic alu_hs;
   logic lsu_hs;
   logic elem_hs;
   logic last_elem;
   logic resp_eff;

   assign is_mem    = kind_q[1];
   assign alu_hs    = alu_req_valid & alu_req_ready;
   assign lsu_hs    = lsu_req_valid & lsu_req_ready;
   assign elem_hs   = alu_hs | lsu_hs;
   assign last_elem = (idx_q == (vl_q - VL_W'(1)));
   assign resp_eff  = lsu_resp_valid & (outst_q != '0);

   assign dec_v_ready    = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign alu_req_valid  = (state_q == S_ISSUE) & ~is_mem;
   assign alu_req_idx    = idx_q;
   assign alu_req_scalar = alu_req_valid & (kind_q == 2'd1);
   // Memory issue is throttled by the number of requests still awaiting a response.
   assign lsu_req_valid  = (state_q == S_ISSUE) & is_mem & (outst_q < OUTST_LIM);
   assign lsu_req_store  = lsu_req_valid & kind_q[0];
   assign lsu_req_addr   = base_q + {{(30-VL_W){1'b0}}, idx_q, 2'b00};
   assign lsu_req_idx    = idx_q;
   assign vreg_vd        = vd_q;
   assign vreg_vs1       = vs1_q;
   assign vreg_vs2       = vs2_q;

   always_comb begin
      outst_d = outst_q;
      if (lsu_hs && !resp_eff) begin
         outst_d = outst_q + OW'(1);
      end else if (!lsu_hs && resp_eff) begin
         outst_d = outst_q - OW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= S_IDLE;
         kind_q    <= '0;
         vl_q      <= '0;
         idx_q     <= '0;
         vd_q      <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         base_q    <= '0;
         outst_q   <= '0;
         flushed_q <= 1'b0;
      end else begin
         outst_q <= outst_d;
         if (elem_hs) begin
            idx_q <= idx_q + VL_W'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (dec_v_valid) begin
                  kind_q    <= dec_v_kind;
                  vl_q      <= (dec_v_vl > VL_LIM) ? VL_LIM : dec_v_vl;
                  vd_q      <= dec_v_vd;
                  vs1_q     <= dec_v_vs1;
                  vs2_q     <= dec_v_vs2;
                  base_q    <= dec_v_base;
                  idx_q     <= '0;
                  flushed_q <= 1'b0;
                  state_q   <= (dec_v_vl == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A flushed instruction still waits for its in-flight responses but never reports done.
               if (flush) begin
                  if (outst_d != '0) begin
                     flushed_q <= 1'b1;
                     state_q   <= S_DRAIN;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (elem_hs && last_elem) begin
                  state_q <= (is_mem && (outst_d != '0)) ? S_DRAIN : S_DONE;
               end
            end
            S_DRAIN: begin
               if (flush) begin
                  flushed_q <= 1'b1;
               end
               if (outst_d == '0) begin
                  state_q <= (flushed_q || flush) ? S_IDLE : S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef RV_VEC_SEQ_PERF_EN
   logic [31:0] perf_elem_q;
   logic [31:0] perf_stall_q;
   logic        stall;

   assign stall          = (alu_req_valid & ~alu_req_ready) | (lsu_req_valid & ~lsu_req_ready);
   assign perf_elem_cnt  = perf_elem_q;
   assign perf_stall_cnt = perf_stall_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         perf_elem_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (elem_hs && (perf_elem_q != '1)) begin
            perf_elem_q <= perf_elem_q + 32'd1;
         end
         if (stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dec_vec_seq.sv
// tb/tb_dec_vec_seq.sv - scoreboard bench for dec_vec_seq
// Directed vectors push expected element/done events; a negedge monitor pops and compares.
module tb_dec_vec_seq;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        flush = 1'b0;
   logic        dec_v_valid = 1'b0;
   logic        dec_v_ready;
   logic [1:0]  dec_v_kind = '0;
   logic [3:0]  dec_v_vl = '0;
   logic [4:0]  dec_v_vd = '0;
   logic [4:0]  dec_v_vs1 = '0;
   logic [4:0]  dec_v_vs2 = '0;
   logic [31:0] dec_v_base = '0;
   logic        alu_req_valid;
   logic        alu_req_ready = 1'b0;
   logic [3:0]  alu_req_idx;
   logic        alu_req_scalar;
   logic        lsu_req_valid;
   logic        lsu_req_ready = 1'b0;
   logic        lsu_req_store;
   logic [31:0] lsu_req_addr;
   logic [3:0]  lsu_req_idx;
   logic        lsu_resp_valid;
   logic [4:0]  vreg_vd;
   logic [4:0]  vreg_vs1;
   logic [4:0]  vreg_vs2;
   logic        busy;
   logic        done;
`ifdef RV_VEC_SEQ_PERF_EN
   logic [31:0] perf_elem_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] stall0;
`endif

   always #5 clk = ~clk;

   dec_vec_seq #(.VL_MAX(8), .VL_W(4), .MAX_OUTST(4)) dut (
      .clk(clk), .rst_l(rst_l), .flush(flush),
      .dec_v_valid(dec_v_valid), .dec_v_ready(dec_v_ready), .dec_v_kind(dec_v_kind),
      .dec_v_vl(dec_v_vl), .dec_v_vd(dec_v_vd), .dec_v_vs1(dec_v_vs1), .dec_v_vs2(dec_v_vs2),
      .dec_v_base(dec_v_base),
      .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready), .alu_req_idx(alu_req_idx),
      .alu_req_scalar(alu_req_scalar),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_store(lsu_req_store),
      .lsu_req_addr(lsu_req_addr), .lsu_req_idx(lsu_req_idx), .lsu_resp_valid(lsu_resp_valid),
      .vreg_vd(vreg_vd), .vreg_vs1(vreg_vs1), .vreg_vs2(vreg_vs2),
      .busy(busy), .done(done)
`ifdef RV_VEC_SEQ_PERF_EN
      , .perf_elem_cnt(perf_elem_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   typedef struct packed {
      logic [1:0]  typ;
      logic [3:0]  idx;
      logic [31:0] addr;
      logic        flag;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  mon_ob;
   ev_t  mon_e;
   logic mon_have;
   int   checks = 0;
   int   failures = 0;
   int   n_lsu_hs = 0;
   int   n_done = 0;
   int   h0;
   int   d0;

   // Simple LSU model: each accepted request is answered two cycles later.
   logic       auto_resp = 1'b0;
   logic       man_resp = 1'b0;
   logic [1:0] hs_pipe = '0;
   always @(posedge clk) hs_pipe <= {hs_pipe[0], lsu_req_valid & lsu_req_ready};
   assign lsu_resp_valid = man_resp | (auto_resp & hs_pipe[1]);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_l) begin
         mon_have = 1'b0;
         mon_ob   = '0;
         if (alu_req_valid && alu_req_ready) begin
            mon_ob.typ = 2'd0; mon_ob.idx = alu_req_idx; mon_ob.flag = alu_req_scalar; mon_have = 1'b1;
         end else if (lsu_req_valid && lsu_req_ready) begin
            mon_ob.typ = 2'd1; mon_ob.idx = lsu_req_idx; mon_ob.addr = lsu_req_addr;
            mon_ob.flag = lsu_req_store; mon_have = 1'b1; n_lsu_hs++;
         end else if (done) begin
            mon_ob.typ = 2'd2; mon_have = 1'b1; n_done++;
         end
         if (mon_have) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got typ=%0d idx=%0d addr=0x%0h flag=%0d, required no event",
                        mon_ob.typ, mon_ob.idx, mon_ob.addr, mon_ob.flag);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_ob !== mon_e) begin
                  failures++;
                  $display("FAIL sb_event: got typ=%0d idx=%0d addr=0x%0h flag=%0d, required typ=%0d idx=%0d addr=0x%0h flag=%0d",
                           mon_ob.typ, mon_ob.idx, mon_ob.addr, mon_ob.flag,
                           mon_e.typ, mon_e.idx, mon_e.addr, mon_e.flag);
               end
            end
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_alu(input int idx, input logic sc);
      ev_t e;
      e = '0; e.typ = 2'd0; e.idx = 4'(idx); e.flag = sc;
      exp_q.push_back(e);
   endtask

   task automatic push_lsu(input int idx, input logic [31:0] addr, input logic st);
      ev_t e;
      e = '0; e.typ = 2'd1; e.idx = 4'(idx); e.addr = addr; e.flag = st;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      ev_t e;
      e = '0; e.typ = 2'd2;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] k, input int vl, input logic [31:0] base);
      int t;
      t = 0;
      while (!dec_v_ready && t < 200) begin cyc(); t++; end
      chk("issue_ready_timeout", {31'd0, dec_v_ready}, 32'd1);
      dec_v_kind = k; dec_v_vl = 4'(vl); dec_v_base = base;
      dec_v_vd = 5'd3; dec_v_vs1 = 5'd17; dec_v_vs2 = 5'd30;
      dec_v_valid = 1'b1;
      cyc();
      dec_v_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int t;
      t = 0;
      while (!(dec_v_ready && exp_q.size() == 0) && t < maxc) begin cyc(); t++; end
      chk(name, {31'd0, dec_v_ready && exp_q.size() == 0}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      #2 rst_l = 1'b1;
      cyc();
      // Reset state
      chk("rst_ready", {31'd0, dec_v_ready}, 32'd1);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      chk("rst_valids", {30'd0, alu_req_valid, lsu_req_valid}, 32'd0);
      chk("rst_vregs", {17'd0, vreg_vd, vreg_vs1, vreg_vs2}, 32'd0);
      chk("rst_addr", lsu_req_addr, 32'd0);
`ifdef RV_VEC_SEQ_PERF_EN
      chk("rst_perf", perf_elem_cnt | perf_stall_cnt, 32'd0);
`endif

      // vv arith, vl=4, no backpressure
      alu_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_alu(i, 1'b0);
      push_done();
      issue(2'd0, 4, 32'd0);
      chk("t1_vregs", {17'd0, vreg_vd, vreg_vs1, vreg_vs2}, {17'd0, 5'd3, 5'd17, 5'd30});
      for (int i = 0; i < 4; i++) begin
         chk("t1_idx_seq", {27'd0, alu_req_valid, alu_req_idx}, 32'h10 + 32'(i));
         cyc();
      end
      chk("t1_done", {29'd0, done, busy, dec_v_ready}, 32'b110);
      cyc();
      chk("t1_ready_back", {29'd0, done, busy, dec_v_ready}, 32'b001);

      // vx arith, vl above VL_MAX is clamped to 8 elements
      for (int i = 0; i < 8; i++) push_alu(i, 1'b1);
      push_done();
      issue(2'd1, 15, 32'd0);
      wait_idle("t2_clamp_complete", 40);

      // ALU backpressure of 3 cycles on element 1
`ifdef RV_VEC_SEQ_PERF_EN
      stall0 = perf_stall_cnt;
`endif
      for (int i = 0; i < 3; i++) push_alu(i, 1'b0);
      push_done();
      issue(2'd0, 3, 32'd0);
      cyc();
      alu_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_hold_idx1", {27'd0, alu_req_valid, alu_req_idx}, 32'h11);
         cyc();
      end
      alu_req_ready = 1'b1;
      chk("t3_release_idx1", {27'd0, alu_req_valid, alu_req_idx}, 32'h11);
      wait_idle("t3_complete", 20);
`ifdef RV_VEC_SEQ_PERF_EN
      chk("t3_perf_stall", perf_stall_cnt - stall0, 32'd3);
`endif

      // v_load base 0x1000, vl=3, responses two cycles after each request
      auto_resp = 1'b1; lsu_req_ready = 1'b1;
      push_lsu(0, 32'h1000, 1'b0); push_lsu(1, 32'h1004, 1'b0); push_lsu(2, 32'h1008, 1'b0);
      push_done();
      d0 = n_done;
      issue(2'd2, 3, 32'h1000);
      chk("t4_first_addr", lsu_req_addr, 32'h1000);
      cyc(3);
      chk("t4_drain", {29'd0, lsu_req_valid, busy, done}, 32'b010);
      cyc();
      chk("t4_drain2", {31'd0, done}, 32'd0);
      cyc();
      chk("t4_done", {31'd0, done}, 32'd1);
      wait_idle("t4_complete", 20);
      chk("t4_done_once", 32'(n_done - d0), 32'd1);
      auto_resp = 1'b0;
      cyc(3);

      // v_store vl=8 with no responses: only MAX_OUTST requests may issue
      for (int i = 0; i < 8; i++) push_lsu(i, 32'h4000 + 32'(4 * i), 1'b1);
      push_done();
      h0 = n_lsu_hs;
      issue(2'd3, 8, 32'h4000);
      cyc(8);
      chk("t5_outst_limit", 32'(n_lsu_hs - h0), 32'd4);
      chk("t5_valid_low", {31'd0, lsu_req_valid}, 32'd0);
      for (int r = 0; r < 8; r++) begin
         man_resp = 1'b1;
         cyc();
         man_resp = 1'b0;
         if (r < 4) chk("t5_released", {31'd0, lsu_req_valid}, 32'd1);
         chk("t5_done_at_last", {31'd0, done}, (r == 7) ? 32'd1 : 32'd0);
         cyc();
      end
      wait_idle("t5_complete", 10);

      // vl=0: done the cycle after accept, no requests
      push_done();
      issue(2'd0, 0, 32'd0);
      chk("t6_vl0_done", {29'd0, done, busy, alu_req_valid}, 32'b110);
      cyc();
      chk("t6_vl0_idle", {30'd0, dec_v_ready, done}, 32'b10);

      // Flush at idx=2 of a 6-element load with 2 outstanding
      push_lsu(0, 32'h2000, 1'b0); push_lsu(1, 32'h2004, 1'b0);
      d0 = n_done;
      issue(2'd2, 6, 32'h2000);
      cyc(2);
      chk("t7_at_idx2", {27'd0, lsu_req_valid, lsu_req_idx}, 32'h12);
      lsu_req_ready = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0; lsu_req_ready = 1'b1;
      chk("t7_no_issue", {30'd0, lsu_req_valid, busy}, 32'b01);
      cyc(3);
      chk("t7_still_drain", {29'd0, lsu_req_valid, busy, dec_v_ready}, 32'b010);
      man_resp = 1'b1;
      cyc(2);
      man_resp = 1'b0;
      chk("t7_idle_no_done", {29'd0, dec_v_ready, busy, done}, 32'b100);
      cyc(2);
      chk("t7_done_never", 32'(n_done - d0), 32'd0);
      chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

      // Store with 32-bit address wrap
      auto_resp = 1'b1;
      push_lsu(0, 32'hFFFF_FFF8, 1'b1); push_lsu(1, 32'hFFFF_FFFC, 1'b1); push_lsu(2, 32'h0000_0000, 1'b1);
      push_done();
      issue(2'd3, 3, 32'hFFFF_FFF8);
      wait_idle("t8_wrap_complete", 20);
      auto_resp = 1'b0;
      cyc(3);

      // Asynchronous reset in the middle of a store
      push_lsu(0, 32'h5000, 1'b1); push_lsu(1, 32'h5004, 1'b1);
      issue(2'd3, 8, 32'h5000);
      cyc(2);
      #2 rst_l = 1'b0;
      exp_q.delete();
      #1;
      chk("t9_async_reset", {28'd0, dec_v_ready, busy, lsu_req_valid, done}, 32'b1000);
      chk("t9_vregs_cleared", {27'd0, vreg_vd}, 32'd0);
      @(posedge clk); #1;
      rst_l = 1'b1;
      man_resp = 1'b1;
      cyc();
      man_resp = 1'b0;
      chk("t9_stray_resp", {30'd0, dec_v_ready, busy}, 32'b10);
      auto_resp = 1'b1;
      push_lsu(0, 32'h6000, 1'b0); push_lsu(1, 32'h6004, 1'b0);
      push_done();
      issue(2'd2, 2, 32'h6000);
      wait_idle("t9_after_reset_complete", 20);

      cyc(5);
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
